// File: rtl/aes_round_scheduler.sv
// Slot-ring scheduler for an iterative AES-128 round loop: admits, recirculates
// and retires blocks, and drains ciphertext into a credit-protected output FIFO.
module aes_round_scheduler #(
  parameter int NSTAGE    = 6,
  parameter int NROUNDS   = 10,
  parameter int OUT_DEPTH = 8,
  parameter int TAG_W     = 4,
  localparam int PTR_W    = (NSTAGE > 1) ? $clog2(NSTAGE) : 1,
  localparam int CNT_W    = $clog2(OUT_DEPTH + NSTAGE + 1),
  localparam int AW       = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  input  logic [127:0]      in_key,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [127:0]      loop_data_in,
  input  logic [127:0]      loop_key_in,
  output logic              issue_valid,
  output logic [127:0]      issue_data,
  output logic [127:0]      issue_key,
  output logic [7:0]        issue_rcon,
  output logic [3:0]        issue_round,
  output logic              issue_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [PTR_W-1:0]  dbg_ptr,
  output logic [CNT_W-1:0]  dbg_inflight,
  output logic [CNT_W-1:0]  dbg_fifo_count
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; in_ready never depends on in_valid, and out_valid/out_data never depend on out_ready.
  localparam logic [3:0] NR = 4'(NROUNDS);

  logic [PTR_W-1:0]       r_ptr;
  logic                   r_occ [NSTAGE];
  logic [3:0]             r_rnd [NSTAGE];
  logic [TAG_W-1:0]       r_tag [NSTAGE];
  logic [CNT_W-1:0]       r_inflight;
  logic [CNT_W-1:0]       r_count;
  logic [AW-1:0]          r_wr;
  logic [AW-1:0]          r_rd;
  logic [128+TAG_W-1:0]   r_mem [OUT_DEPTH];

  logic                   w_occ;
  logic [3:0]             w_rnd;
  logic [3:0]             w_next_rnd;
  logic                   w_complete;
  logic                   w_recirc;
  logic                   w_admit;
  logic                   w_pop;
  logic                   w_credit;
  logic [128+TAG_W-1:0]   w_head;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    rcon_of = 8'h01;
      4'd2:    rcon_of = 8'h02;
      4'd3:    rcon_of = 8'h04;
      4'd4:    rcon_of = 8'h08;
      4'd5:    rcon_of = 8'h10;
      4'd6:    rcon_of = 8'h20;
      4'd7:    rcon_of = 8'h40;
      4'd8:    rcon_of = 8'h80;
      4'd9:    rcon_of = 8'h1B;
      4'd10:   rcon_of = 8'h36;
      default: rcon_of = 8'h00;
    endcase
  endfunction

  always_comb begin
    w_occ      = r_occ[r_ptr];
    w_rnd      = r_rnd[r_ptr];
    w_next_rnd = w_rnd + 4'd1;
    w_complete = w_occ && (w_rnd == NR);
    w_recirc   = w_occ && !w_complete;
    // Every block in flight already owns a FIFO entry, so a completion can never overflow.
    w_credit   = (r_inflight + r_count) < CNT_W'(OUT_DEPTH);
    in_ready   = (!w_occ || w_complete) && w_credit;
    w_admit    = in_valid && in_ready;
    w_head     = r_mem[r_rd];
    out_valid  = (r_count != '0);
    out_data   = out_valid ? w_head[TAG_W +: 128] : '0;
    out_tag    = out_valid ? w_head[TAG_W-1:0] : '0;
    w_pop      = out_valid && out_ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr       <= '0;
      r_inflight  <= '0;
      issue_valid <= 1'b0;
      issue_data  <= '0;
      issue_key   <= '0;
      issue_rcon  <= '0;
      issue_round <= '0;
      issue_last  <= 1'b0;
      for (int i = 0; i < NSTAGE; i++) begin
        r_occ[i] <= 1'b0;
        r_rnd[i] <= '0;
        r_tag[i] <= '0;
      end
    end else begin
      r_ptr       <= (r_ptr == PTR_W'(NSTAGE - 1)) ? '0 : r_ptr + PTR_W'(1);
      issue_valid <= 1'b0;
      issue_data  <= '0;
      issue_key   <= '0;
      issue_rcon  <= '0;
      issue_round <= '0;
      issue_last  <= 1'b0;
      if (w_recirc) begin
        issue_valid    <= 1'b1;
        issue_data     <= loop_data_in;
        issue_key      <= loop_key_in;
        issue_round    <= w_next_rnd;
        issue_rcon     <= rcon_of(w_next_rnd);
        issue_last     <= (w_next_rnd == NR);
        r_rnd[r_ptr]   <= w_next_rnd;
      end else if (w_admit) begin
        issue_valid    <= 1'b1;
        issue_data     <= in_data;
        issue_key      <= in_key;
        issue_round    <= 4'd1;
        issue_rcon     <= rcon_of(4'd1);
        issue_last     <= (NR == 4'd1);
        r_occ[r_ptr]   <= 1'b1;
        r_rnd[r_ptr]   <= 4'd1;
        r_tag[r_ptr]   <= in_tag;
      end else if (w_complete) begin
        r_occ[r_ptr]   <= 1'b0;
      end
      case ({w_admit, w_complete})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Output FIFO; storage is not reset because reads are gated by r_count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_complete)
        r_wr <= (r_wr == AW'(OUT_DEPTH - 1)) ? '0 : r_wr + AW'(1);
      if (w_pop)
        r_rd <= (r_rd == AW'(OUT_DEPTH - 1)) ? '0 : r_rd + AW'(1);
      case ({w_complete, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_complete && !reset)
      r_mem[r_wr] <= {loop_data_in, r_tag[r_ptr]};
  end

  assign dbg_ptr        = r_ptr;
  assign dbg_inflight   = r_inflight;
  assign dbg_fifo_count = r_count;

endmodule
